// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encoding, default line rate and
// helpers that derive the bit period and its counter width.
package uart_defs;

   localparam int DEF_CLK_FREQ = 12_000_000;
   localparam int DEF_BAUD     = 115_200;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int calc_cnt_width(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; 2 clocks latency, reset value
// is a parameter so idle-high lines do not glitch low out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: VALID_o pulses 2 + CPB/2 + 9*CPB + 1 clocks after the start edge; no backpressure.
// Optional even parity bit when UART_RX_PARITY_EN is defined (adds one bit period of latency).
module uart_rx_deser
   import uart_defs::*;
#(
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int BAUD         = DEF_BAUD,
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
   input  logic       CLK_IN,
   input  logic       RESET_N_IN,
   input  logic       UART_RX_i,
   output logic [7:0] DATA_o,
   output logic       VALID_o,
   output logic       FRAME_ERR_o,
   output logic       PARITY_ERR_o,
   output logic       BUSY_o
);

   localparam int            CW      = calc_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   logic          rx_s;
   uart_state_t   state, state_nxt;
   logic [CW-1:0] clk_cnt, cnt_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [7:0]    data, data_nxt;
   logic          valid, valid_nxt;
   logic          ferr, ferr_nxt;
   logic          busy;
   logic          bit_end;
`ifdef UART_RX_PARITY_EN
   logic          par_bit, par_nxt;
   logic          perr, perr_nxt;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (CLK_IN),
      .rst_n (RESET_N_IN),
      .d     (UART_RX_i),
      .q     (rx_s)
   );

   assign bit_end = (clk_cnt == BIT_M1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = clk_cnt + CW'(1);
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      data_nxt  = data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt   = par_bit;
      perr_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Re-check at mid start bit to reject short glitches
            if (clk_cnt == HALF_M1) begin
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DATA;
                  bit_nxt   = 3'd0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = {rx_s, shift[7:1]};
               cnt_nxt   = '0;
               bit_nxt   = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
               if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               par_nxt   = rx_s;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (rx_s) begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (^{shift, par_bit}) begin
                     perr_nxt = 1'b1;
                  end else begin
                     valid_nxt = 1'b1;
                     data_nxt  = shift;
                  end
`else
                  valid_nxt = 1'b1;
                  data_nxt  = shift;
`endif
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
         data    <= 8'h00;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         clk_cnt <= cnt_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         data    <= data_nxt;
         valid   <= valid_nxt;
         ferr    <= ferr_nxt;
         busy    <= (state_nxt != IDLE);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         par_bit <= 1'b0;
         perr    <= 1'b0;
      end else begin
         par_bit <= par_nxt;
         perr    <= perr_nxt;
      end
   end
   assign PARITY_ERR_o = perr;
`else
   assign PARITY_ERR_o = 1'b0;
`endif

   assign DATA_o      = data;
   assign VALID_o     = valid;
   assign FRAME_ERR_o = ferr;
   assign BUSY_o      = busy;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames are driven bit by bit and the expected
// strobe for each is queued, then matched by a monitor when the DUT reports it.
`timescale 1ns/1ps
module tb_uart_rx_deser;
   import uart_defs::*;

   localparam int CPB = calc_clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);
`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 2 + CPB/2 + 10*CPB + 1;
`else
   localparam int EXP_LAT = 2 + CPB/2 + 9*CPB + 1;
`endif

   typedef enum int {EV_VALID = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      int         start;
      int         lat;
   } ev_t;

   ev_t        sb[$];
   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid, ferr, perr, busy;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   int         exp_valid = 0, exp_ferr = 0, exp_perr = 0;
   int         n_valid = 0, n_ferr = 0, n_perr = 0;
   logic [7:0] last_exp = 8'h00;

   uart_rx_deser dut (
      .CLK_IN       (clk),
      .RESET_N_IN   (rst_n),
      .UART_RX_i    (rx),
      .DATA_o       (data),
      .VALID_o      (valid),
      .FRAME_ERR_o  (ferr),
      .PARITY_ERR_o (perr),
      .BUSY_o       (busy)
   );

   initial clk = 1'b0;
   always #41.667 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_wait();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Drives one frame starting at the current (posedge + 1ns) phase and queues its outcome.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic par_bit, input logic lat_chk);
      ev_t e;
      e.data  = b;
      e.start = cyc;
      e.lat   = lat_chk ? EXP_LAT : -1;
      if (!stop_bit) begin
         e.kind = EV_FERR; exp_ferr++;
`ifdef UART_RX_PARITY_EN
      end else if (^{b, par_bit}) begin
         e.kind = EV_PERR; exp_perr++;
`endif
      end else begin
         e.kind = EV_VALID; exp_valid++;
      end
      sb.push_back(e);
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         bit_wait();
      end
`ifdef UART_RX_PARITY_EN
      rx = par_bit;
      bit_wait();
`endif
      rx = stop_bit;
      bit_wait();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && (valid || ferr || perr)) begin
         ev_t e;
         if (valid) n_valid++;
         if (ferr)  n_ferr++;
         if (perr)  n_perr++;
         chk("one_strobe", $countones({valid, ferr, perr}), 1);
         chk("event_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("event_kind", valid ? EV_VALID : (ferr ? EV_FERR : EV_PERR), e.kind);
            if (e.kind == EV_VALID) begin
               chk("data", data, e.data);
               last_exp = e.data;
            end else begin
               chk("data_hold", data, last_exp);
            end
            if (e.lat >= 0) chk("latency", cyc - e.start, e.lat);
         end
      end
   end

   initial begin
      #(60000 * 84);
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      rst_n = 1'b0;
      rx    = 1'b1;
      #200;
      chk("rst_data", data, 8'h00);
      chk("rst_valid", valid, 0);
      chk("rst_ferr", ferr, 0);
      chk("rst_perr", perr, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1000;
      @(posedge clk);
      #1;

      // single byte with latency check
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      wait_drain();
      chk("busy_after_55", busy, 0);
      chk("data_55", data, 8'h55);

      // back-to-back, zero idle
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      wait_drain();
      chk("data_ff", data, 8'hFF);

      // 20-clock low glitch
      rx = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (i == 19) begin
            @(posedge clk);
            #1;
            rx = 1'b1;
         end
      end
      chk("glitch_busy_cycles", busy_cnt, 52);
      chk("glitch_busy_end", busy, 0);
      @(posedge clk);
      #1;

      // framing error followed by a held-low break
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (3) bit_wait();
      chk("break_busy", busy, 1);
      rx = 1'b1;
      bit_wait();
      wait_drain();
      chk("data_after_ferr", data, 8'hFF);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      wait_drain();
      chk("data_3c", data, 8'h3C);

      // reset after 4 data bits of 0xF0
      rx = 1'b0;
      bit_wait();
      for (int i = 0; i < 4; i++) begin
         rx = 1'b0;
         bit_wait();
      end
      chk("midframe_busy", busy, 1);
      rst_n = 1'b0;
      last_exp = 8'h00;
      #2;
      chk("mid_rst_data", data, 8'h00);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_ferr", ferr, 0);
      rx = 1'b1;
      #8;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bit_wait();
      bit_wait();
      chk("post_rst_queue", sb.size(), 0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      wait_drain();
      chk("data_81", data, 8'h81);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      wait_drain();
      chk("data_07", data, 8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      wait_drain();
`endif

      repeat (20) @(posedge clk);
      chk("n_valid", n_valid, exp_valid);
      chk("n_ferr", n_ferr, exp_ferr);
      chk("n_perr", n_perr, exp_perr);
      chk("final_busy", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
